// File: rtl/fifo_sync_pkg.sv
// Shared helpers for the async FIFO pointer synchronisers: Gray/binary conversion,
// popcount and a width-parameterised pointer type macro.
`ifndef FIFO_SYNC_PKG_SV
`define FIFO_SYNC_PKG_SV

// Pointer type is ADDR_SIZE+1 bits (wrap bit on top); packages cannot take parameters.
`define FIFO_PTR_T(asz) logic [(asz):0]

package fifo_sync_pkg;

  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly: the leading zeros do not alter the xor prefix.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FN_W; i++) n += {31'b0, v[i]};
    return n;
  endfunction

endpackage

`endif

// File: rtl/sync_chain.sv
// Generic multi-bit flop chain for clock-domain crossing of Gray pointers.
// Pure flops between stages; no logic is inserted anywhere in the chain.
module sync_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rptr_sync_wstatus.sv
// Write-side read-pointer synchroniser: brings the Gray read pointer into write_clk,
// converts it to binary and derives fill level, full/almost_full and sticky error flags.
module rptr_sync_wstatus
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_SIZE    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic               write_clk,
  input  logic               wreset_n,
  input  logic [ADDR_SIZE:0] read_pointer_gray,
  input  logic [ADDR_SIZE:0] write_pointer_bin,
  input  logic               err_clear,
  output logic [ADDR_SIZE:0] read_pointer_s,
  output logic [ADDR_SIZE:0] read_pointer_bin_s,
  output logic               rptr_advance,
  output logic [ADDR_SIZE:0] fill_level,
  output logic               full,
  output logic               almost_full,
  output logic               gray_error,
  output logic               ptr_error
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam int DEPTH = 2 ** ADDR_SIZE;

  typedef `FIFO_PTR_T(ADDR_SIZE) ptr_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("rptr_sync_wstatus: SYNC_STAGES must be in 2..4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("rptr_sync_wstatus: AFULL_THRESH must be in 1..2**ADDR_SIZE");
  end

  ptr_t        prev;
  ptr_t        bin_next;
  logic [31:0] bin_wide;
  logic        gray_set;
  logic        ptr_set;
  logic        unused_bin_hi;

  sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_sys (write_clk),
    .rst_b   (wreset_n),
    .d       (read_pointer_gray),
    .q       (read_pointer_s)
  );

  assign bin_wide      = gray2bin(32'(read_pointer_s));
  assign bin_next      = bin_wide[PTR_W-1:0];
  assign unused_bin_hi = ^bin_wide[31:PTR_W];

  // A legal Gray stream moves at most one bit per sampled cycle.
  assign gray_set = popcount(32'(read_pointer_s ^ prev)) > 1;

  // Status uses only the registered binary pointer, never the raw crossing input.
  assign fill_level  = write_pointer_bin - read_pointer_bin_s;
  assign full        = (fill_level == PTR_W'(DEPTH));
  assign almost_full = (fill_level >= PTR_W'(AFULL_THRESH));
  assign ptr_set     = (fill_level > PTR_W'(DEPTH));

  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      prev               <= '0;
      read_pointer_bin_s <= '0;
      rptr_advance       <= 1'b0;
      gray_error         <= 1'b0;
      ptr_error          <= 1'b0;
    end else begin
      prev               <= read_pointer_s;
      read_pointer_bin_s <= bin_next;
      rptr_advance       <= (read_pointer_s != prev);
      // A new violation wins over a clear arriving in the same cycle.
      gray_error         <= gray_set | (gray_error & ~err_clear);
      ptr_error          <= ptr_set  | (ptr_error  & ~err_clear);
    end
  end

endmodule
